// File: rtl/gpio_led_ctrl_if.sv
// Board-side bundle of gpio_led_ctrl: micro command/response words, raw switches and RGB LED pins.
interface gpio_led_ctrl_if #(
   parameter int NB_GPIOS   = 32,
   parameter int N_RGB      = 4,
   parameter int NB_SWITCHS = 4
);
   logic [NB_GPIOS-1:0]   i_gpo;
   logic [NB_GPIOS-1:0]   o_gpi;
   logic [NB_SWITCHS-1:0] i_sw;
   logic [3*N_RGB-1:0]    o_leds_rgb;

   modport master (output i_gpo, output i_sw, input o_gpi, input o_leds_rgb);
   modport slave  (input i_gpo, input i_sw, output o_gpi, output o_leds_rgb);
endinterface

// File: rtl/gpio_led_ctrl.sv
// Toggle-handshake GPIO register bridge driving RGB PWM LEDs and returning switch state; response 2 clocks after a
// REQ toggle, no backpressure (software waits for ACK == REQ). GPIO_LED_CTRL_DEBOUNCE_EN adds per-switch debouncers.
module gpio_led_ctrl #(
   parameter int NB_GPIOS    = 32,
   parameter int N_RGB       = 4,
   parameter int NB_PWM      = 8,
   parameter int NB_SWITCHS  = 4,
   parameter int NB_DEBOUNCE = 16
) (
   input logic            clk,
   input logic            rst,
   gpio_led_ctrl_if.slave bus
);
   localparam logic [5:0]  ADDR_CTRL = 6'h10;
   localparam logic [5:0]  ADDR_SW   = 6'h20;
   localparam logic [5:0]  ADDR_INFO = 6'h21;
   localparam logic [23:0] INFO_VAL  = {8'(N_RGB), 8'(NB_PWM), 8'(NB_SWITCHS)};

   if (NB_GPIOS != 32 || N_RGB < 1 || N_RGB > 16 || NB_PWM < 1 || NB_PWM > 8 ||
       NB_SWITCHS < 1 || NB_SWITCHS > 24 || NB_DEBOUNCE < 1) begin : g_param_check
      $error("gpio_led_ctrl: parameter out of range");
   end

   logic [NB_GPIOS-1:0]               gpo_q;
   logic [NB_GPIOS-1:0]               gpi_q;
   logic [N_RGB-1:0][2:0][NB_PWM-1:0] duty_shd;
   logic [N_RGB-1:0][2:0][NB_PWM-1:0] duty_act;
   logic                              ctrl_en;
   logic                              ctrl_inv;
   logic [NB_PWM-1:0]                 pwm_cnt;
   logic [3*N_RGB-1:0]                led_q;
   logic [NB_SWITCHS-1:0]             sw_meta;
   logic [NB_SWITCHS-1:0]             sw_sync;
   logic [NB_SWITCHS-1:0]             sw_state;

   // ---------------- switch synchroniser / debouncer ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_meta <= '0;
         sw_sync <= '0;
      end else begin
         sw_meta <= bus.i_sw;
         sw_sync <= sw_meta;
      end
   end

`ifdef GPIO_LED_CTRL_DEBOUNCE_EN
   localparam logic [NB_DEBOUNCE-1:0] DB_ALL  = '1;
   localparam logic [NB_DEBOUNCE-1:0] DB_LAST = DB_ALL - 1'b1;

   logic [NB_SWITCHS-1:0][NB_DEBOUNCE-1:0] db_cnt;

   // The counter update that would land on all-ones commits the new level instead.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_cnt   <= '0;
         sw_state <= '0;
      end else begin
         for (int i = 0; i < NB_SWITCHS; i++) begin
            if (sw_sync[i] == sw_state[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               sw_state[i] <= sw_sync[i];
               db_cnt[i]   <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end
`else
   assign sw_state = sw_sync;
`endif

   // ---------------- command decode ----------------
   logic                     req_pend;
   logic                     rw;
   logic [5:0]               addr;
   logic [23:0]              wdata;
   logic [2:0][NB_PWM-1:0]   wr_duty;
   logic [2:0][NB_PWM-1:0]   rd_duty;
   logic                     acc_err;
   logic [23:0]              rdata;

   assign req_pend = gpo_q[31] ^ gpi_q[31];
   assign rw       = gpo_q[30];
   assign addr     = gpo_q[29:24];
   assign wdata    = gpo_q[23:0];
   assign wr_duty  = {wdata[16 +: NB_PWM], wdata[8 +: NB_PWM], wdata[0 +: NB_PWM]};

   function automatic logic [23:0] duty_word(input logic [2:0][NB_PWM-1:0] d);
      return {8'(d[2]), 8'(d[1]), 8'(d[0])};
   endfunction

   always_comb begin
      acc_err = 1'b0;
      rdata   = '0;
      rd_duty = '0;
      for (int k = 0; k < N_RGB; k++) begin
         if (addr == 6'(k)) rd_duty = duty_shd[k];
      end
      if (addr < 6'(N_RGB)) begin
         rdata = duty_word(rw ? wr_duty : rd_duty);
      end else if (addr == ADDR_CTRL) begin
         rdata = rw ? {22'd0, wdata[1:0]} : {22'd0, ctrl_inv, ctrl_en};
      end else if (addr == ADDR_SW && !rw) begin
         rdata = 24'(sw_state);
      end else if (addr == ADDR_INFO && !rw) begin
         rdata = INFO_VAL;
      end else begin
         acc_err = 1'b1;
      end
   end

   // ---------------- transaction engine ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gpo_q    <= '0;
         gpi_q    <= '0;
         duty_shd <= '0;
         ctrl_en  <= 1'b1;
         ctrl_inv <= 1'b0;
      end else begin
         gpo_q <= bus.i_gpo;
         if (req_pend) begin
            gpi_q <= {gpo_q[31], acc_err, 6'd0, rdata};
            if (rw && !acc_err) begin
               for (int k = 0; k < N_RGB; k++) begin
                  if (addr == 6'(k)) duty_shd[k] <= wr_duty;
               end
               if (addr == ADDR_CTRL) {ctrl_inv, ctrl_en} <= wdata[1:0];
            end
         end
      end
   end

   // ---------------- PWM ----------------
   // Shadows move to the active set only as the counter wraps, so a running period is never cut short.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_cnt  <= '0;
         duty_act <= '0;
         led_q    <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
         if (pwm_cnt == '1) duty_act <= duty_shd;
         for (int k = 0; k < N_RGB; k++) begin
            for (int c = 0; c < 3; c++) begin
               led_q[3*k+c] <= (ctrl_en && (pwm_cnt < duty_act[k][c])) ^ ctrl_inv;
            end
         end
      end
   end

   assign bus.o_gpi      = gpi_q;
   assign bus.o_leds_rgb = led_q;
endmodule

// File: tb/tb_gpio_led_ctrl.sv
// Randomised bench for gpio_led_ctrl against a register/period-level reference model.
module tb_gpio_led_ctrl;
   localparam int N_RGB       = 4;
   localparam int NB_PWM      = 8;
   localparam int NB_SWITCHS  = 4;
   localparam int NB_DEBOUNCE = 4;
   localparam int PER         = 1 << NB_PWM;
   localparam int NLED        = 3 * N_RGB;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   gpio_led_ctrl_if #(.NB_GPIOS(32), .N_RGB(N_RGB), .NB_SWITCHS(NB_SWITCHS)) bus ();

   gpio_led_ctrl #(
      .NB_GPIOS(32), .N_RGB(N_RGB), .NB_PWM(NB_PWM),
      .NB_SWITCHS(NB_SWITCHS), .NB_DEBOUNCE(NB_DEBOUNCE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Clock edges since reset release; sample after edge t shows PWM count (t-1) mod PER.
   int ecount;
   always @(posedge clk or posedge rst) begin
      if (rst) ecount <= 0;
      else     ecount <= ecount + 1;
   end

   // High-time per LED bit per PWM period.
   int hi_cnt [0:127][0:NLED-1];
   int hq;
   always @(negedge clk) begin
      if (!rst && ecount > 0) begin
         hq = (ecount - 1) / PER;
         if (hq < 128) begin
            for (int b = 0; b < NLED; b++) begin
               if ((ecount - 1) % PER == 0) hi_cnt[hq][b] = 0;
               hi_cnt[hq][b] += int'(bus.o_leds_rgb[b]);
            end
         end
      end
   end

   // Reference model: register contents as software sees them.
   logic        req_t   = 1'b0;
   logic [31:0] gpi_exp = '0;
   logic [23:0] m_duty [N_RGB];
   logic        m_en    = 1'b1;
   logic        m_inv   = 1'b0;
   logic [23:0] m_sw    = '0;
   int          last_w  = 0;

   function automatic logic [23:0] pwm_mask(input logic [23:0] v);
      logic [7:0] m;
      m = 8'((1 << NB_PWM) - 1);
      return v & {m, m, m};
   endfunction

   task automatic model_access(input logic rw, input logic [5:0] addr, input logic [23:0] wdata,
                               output logic [31:0] resp);
      logic        err;
      logic [23:0] rd;
      err = 1'b0;
      rd  = '0;
      if (int'(addr) < N_RGB) begin
         if (rw) m_duty[addr] = pwm_mask(wdata);
         rd = m_duty[addr];
      end else if (addr == 6'h10) begin
         if (rw) begin
            m_en  = wdata[0];
            m_inv = wdata[1];
         end
         rd = {22'd0, m_inv, m_en};
      end else if (addr == 6'h20 && !rw) begin
         rd = m_sw;
      end else if (addr == 6'h21 && !rw) begin
         rd = {8'(N_RGB), 8'(NB_PWM), 8'(NB_SWITCHS)};
      end else begin
         err = 1'b1;
      end
      resp = {req_t, err, 6'd0, err ? 24'd0 : rd};
   endtask

   // Called just after a negedge; returns at the negedge where the response must be visible.
   task automatic tx(input logic rw, input logic [5:0] addr, input logic [23:0] wdata, input string tag);
      logic [31:0] exp;
      req_t = ~req_t;
      bus.i_gpo = {req_t, rw, addr, wdata};
      model_access(rw, addr, wdata, exp);
      @(negedge clk);
      check_eq({tag, "/hold"}, bus.o_gpi, gpi_exp);
      @(negedge clk);
      check_eq(tag, bus.o_gpi, exp);
      gpi_exp = exp;
      last_w  = ecount;
   endtask

   // First period whose active duties were loaded strictly after write edge w.
   task automatic wait_period_after(input int w, output int q);
      q = w / PER + 1;
      while (ecount < (q + 1) * PER + 1) @(negedge clk);
   endtask

   task automatic check_pwm(input int q, input string tag);
      for (int k = 0; k < N_RGB; k++) begin
         for (int c = 0; c < 3; c++) begin
            int d;
            d = int'(m_duty[k][8*c +: 8]);
            if (!m_en) d = 0;
            if (m_inv) d = PER - d;
            check_eq($sformatf("%s_led%0d_c%0d", tag, k, c), 32'(hi_cnt[q][3*k+c]), 32'(d));
         end
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int          q;
      int          w;
      logic [5:0]  a;
      logic [NB_SWITCHS-1:0] sw_new;
      logic [NB_SWITCHS-1:0] sw_old;

      bus.i_gpo = '0;
      bus.i_sw  = '0;
      for (int k = 0; k < N_RGB; k++) m_duty[k] = '0;

      #2;
      check_eq("rst_gpi", bus.o_gpi, 32'h0);
      check_eq("rst_leds", 32'(bus.o_leds_rgb), 32'h0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check_eq("post_rst_leds", 32'(bus.o_leds_rgb), 32'h0);

      // Duty write from the test plan.
      tx(1'b1, 6'h00, 24'hFF8000, "wr_duty0");
      check_eq("wr_duty0_word", bus.o_gpi, 32'h80FF8000);
      wait_period_after(last_w, q);
      check_pwm(q, "duty0");

      // Info, RO write, bad address.
      tx(1'b0, 6'h21, 24'h0, "rd_info");
      check_eq("info_word", {8'h0, bus.o_gpi[23:0]}, 32'h00040804);
      tx(1'b1, 6'h20, 24'h000123, "wr_ro_sw");
      tx(1'b0, 6'h20, 24'h0, "rd_sw_after_ro");
      tx(1'b0, 6'h3F, 24'h0, "rd_bad_3f");

      // Randomised register traffic with steady switches.
      bus.i_sw = NB_SWITCHS'($urandom);
      repeat (40) @(negedge clk);
      m_sw = 24'(bus.i_sw);
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 3))
            0:       a = 6'($urandom_range(0, N_RGB - 1));
            1:       a = 6'h10;
            2:       a = ($urandom_range(0, 1) != 0) ? 6'h20 : 6'h21;
            default: a = 6'($urandom);
         endcase
         tx(1'($urandom), a, 24'($urandom), $sformatf("rnd%0d_a%0h", i, a));
      end
      tx(1'b1, 6'h10, 24'h000001, "ctrl_restore");

      // Random duties on every channel.
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < N_RGB; k++) tx(1'b1, 6'(k), 24'($urandom), $sformatf("rnd_duty%0d", k));
         wait_period_after(last_w, q);
         check_pwm(q, $sformatf("rndpwm%0d", r));
      end

      // Mid-period duty change lands only at the next wrap.
      tx(1'b1, 6'h00, 24'h000040, "glitch_set");
      w = last_w;
      while (!(ecount > w + PER && ecount % PER == 'h1E)) @(negedge clk);
      tx(1'b1, 6'h00, 24'h0000C0, "glitch_upd");
      q = last_w / PER;
      while (ecount < (q + 2) * PER + 1) @(negedge clk);
      check_eq("glitch_old_period", 32'(hi_cnt[q][0]), 32'd64);
      check_eq("glitch_new_period", 32'(hi_cnt[q+1][0]), 32'd192);

      // EN=0, INV=1 drives all LEDs high from the next clock.
      tx(1'b1, 6'h10, 24'h000002, "ctrl_inv");
      @(negedge clk);
      check_eq("inv_leds_next", 32'(bus.o_leds_rgb), 32'((1 << NLED) - 1));
      repeat (100) @(negedge clk);
      check_eq("inv_leds_later", 32'(bus.o_leds_rgb), 32'((1 << NLED) - 1));
      tx(1'b1, 6'h10, 24'h000001, "ctrl_en");
      wait_period_after(last_w, q);
      check_pwm(q, "resume");

      // Switch path.
`ifdef GPIO_LED_CTRL_DEBOUNCE_EN
      bus.i_sw = '0;
      repeat (40) @(negedge clk);
      m_sw = '0;
      bus.i_sw = NB_SWITCHS'(1);
      repeat (5) @(negedge clk);
      bus.i_sw = '0;
      repeat (25) @(negedge clk);
      tx(1'b0, 6'h20, 24'h0, "db_short_pulse");
      bus.i_sw = NB_SWITCHS'(1);
      repeat (15) @(negedge clk);
      tx(1'b0, 6'h20, 24'h0, "db_before_stable");
      bus.i_sw = '0;
      repeat (40) @(negedge clk);
      bus.i_sw = NB_SWITCHS'(1);
      repeat (16) @(negedge clk);
      m_sw = 24'h000001;
      tx(1'b0, 6'h20, 24'h0, "db_stable");
      repeat (4) @(negedge clk);
      tx(1'b0, 6'h20, 24'h0, "db_held");
`else
      for (int i = 0; i < 4; i++) begin
         sw_old = bus.i_sw;
         sw_new = NB_SWITCHS'($urandom);
         bus.i_sw = sw_new;
         m_sw = 24'(sw_old);
         tx(1'b0, 6'h20, 24'h0, $sformatf("sw_lag%0d", i));
         m_sw = 24'(sw_new);
         tx(1'b0, 6'h20, 24'h0, $sformatf("sw_follow%0d", i));
         sw_new = ~sw_new;
         bus.i_sw = sw_new;
         @(negedge clk);
         m_sw = 24'(sw_new);
         tx(1'b0, 6'h20, 24'h0, $sformatf("sw_2clk%0d", i));
      end
`endif

      // Asynchronous reset while LEDs are lit.
      tx(1'b1, 6'h00, 24'hFFFFFF, "full_duty");
      wait_period_after(last_w, q);
      #2 rst = 1'b1;
      #1;
      check_eq("midrst_leds", 32'(bus.o_leds_rgb), 32'h0);
      check_eq("midrst_gpi", bus.o_gpi, 32'h0);
      repeat (2) @(negedge clk);
      check_eq("midrst_leds_held", 32'(bus.o_leds_rgb), 32'h0);
      for (int k = 0; k < N_RGB; k++) m_duty[k] = '0;
      m_en    = 1'b1;
      m_inv   = 1'b0;
      gpi_exp = '0;
      #2 rst = 1'b0;
      if (req_t) model_access(bus.i_gpo[30], bus.i_gpo[29:24], bus.i_gpo[23:0], gpi_exp);
      repeat (3) @(negedge clk);
      check_eq("postrst_pending_tx", bus.o_gpi, gpi_exp);
      tx(1'b0, 6'h10, 24'h0, "postrst_ctrl");
      check_eq("postrst_ctrl_val", {8'h0, bus.o_gpi[23:0]}, 32'h00000001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
